// File: rtl/binary_grid_if.sv
// Read port of the synchronous debug RAM driven by binary_grid_display.
interface binary_grid_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10
);
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_data;

  modport master (output ram_addr, input ram_data);
  modport slave  (input ram_addr, output ram_data);
endinterface

// File: rtl/binary_grid_display.sv
// Debug-RAM binary viewer: RAM words drawn as coloured bit cells with row labels, a column header
// and frame-latched scrolling. Define BINARY_GRID_CURSOR_EN to build the blinking cursor highlight.
module binary_grid_display #(
  parameter int DATA_W    = 8,
  parameter int COLS      = 16,
  parameter int ROWS      = 64,
  parameter int CELL_LOG2 = 3,
  parameter int RAM_LAT   = 1,
  parameter int ADDR_W    = $clog2(ROWS) + $clog2(COLS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [10:0]             counter_x,
  input  logic [10:0]             counter_y,
  input  logic                    in_display,
  input  logic [$clog2(ROWS)-1:0] base_row,
  input  logic [ADDR_W-1:0]       cursor_addr,
  binary_grid_if.master           ram,
  output logic                    vga_r,
  output logic                    vga_g,
  output logic                    vga_b
);
  localparam int ROW_W = $clog2(ROWS);
  localparam int COL_W = $clog2(COLS);
  localparam int PH_W  = $clog2(DATA_W + 1);
  localparam int BS_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [2:0] C_BLACK = 3'b000;
  localparam logic [2:0] C_YEL   = 3'b110;
  localparam logic [2:0] C_BLU   = 3'b001;
  localparam logic [2:0] C_WHT   = 3'b111;
  localparam logic [2:0] C_CYN   = 3'b011;

  typedef struct packed {
    logic            data;
    logic            hit;
    logic [BS_W-1:0] bs;
    logic [2:0]      col;
  } pix_t;

  logic [10:0]       bx, by;
  logic              edge_x, edge_y, frame_start;
  logic [PH_W-1:0]   ph_q, ph_n;
  logic [10:0]       ci_q, ci_n;
  logic [10:0]       ri_q, ri_n;
  logic [ROW_W-1:0]  base_q;
  logic [ROW_W-1:0]  row_r;
  logic [COL_W-1:0]  col_c;
  logic [ADDR_W-1:0] addr_n;
  logic [7:0]        lab8;
  logic [15:0]       ci_ext;
  logic [BS_W-1:0]   bs_n;
  logic              in_data_x;
  logic              hit_n;
  pix_t              nx, tail;
  pix_t              pipe_q [RAM_LAT];
  logic [2:0]        out_col;
  logic              bit_v;

  assign bx          = counter_x >> CELL_LOG2;
  assign by          = counter_y >> CELL_LOG2;
  assign edge_x      = (counter_x[CELL_LOG2-1:0] == '0);
  assign edge_y      = (counter_y[CELL_LOG2-1:0] == '0);
  assign frame_start = (counter_x == '0) && (counter_y == '0);

  // Column phase/index advance at each horizontal cell boundary; held at zero through the label field.
  always_comb begin
    ph_n = ph_q;
    ci_n = ci_q;
    if (counter_x == '0 || (edge_x && bx <= 11'd9)) begin
      ph_n = '0;
      ci_n = '0;
    end else if (edge_x) begin
      if (ph_q == PH_W'(DATA_W)) begin
        ph_n = '0;
        ci_n = ci_q + 11'd1;
      end else begin
        ph_n = ph_q + PH_W'(1);
      end
    end
  end

  // Data row index steps on the first line of every even cell row from by == 4 onwards.
  always_comb begin
    ri_n = ri_q;
    if (counter_y == '0)
      ri_n = '0;
    else if (counter_x == '0 && edge_y && !by[0] && by >= 11'd4)
      ri_n = ri_q + 11'd1;
  end

  assign row_r     = base_q + ri_n[ROW_W-1:0];
  assign col_c     = ci_n[COL_W-1:0];
  assign addr_n    = {row_r, col_c};
  assign lab8      = 8'(row_r);
  assign ci_ext    = {5'b0, ci_n};
  assign bs_n      = BS_W'(DATA_W - 1) - BS_W'(ph_n);
  assign in_data_x = (bx >= 11'd9) && (ci_n < 11'(COLS)) && (ph_n < PH_W'(DATA_W));

`ifdef BINARY_GRID_CURSOR_EN
  logic [5:0] frame_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      frame_cnt <= '0;
    else if (frame_start)
      frame_cnt <= frame_cnt + 6'd1;
  end

  assign hit_n = frame_cnt[5] && (addr_n == cursor_addr);
`else
  logic unused_cursor;
  assign unused_cursor = ^cursor_addr;
  assign hit_n         = 1'b0;
`endif

  // Everything except the RAM bit is resolved here and carried alongside the read.
  always_comb begin
    nx      = '0;
    nx.bs   = bs_n;
    nx.hit  = hit_n;
    nx.col  = C_BLACK;
    nx.data = 1'b0;
    if (!edge_x && !edge_y) begin
      if (by == '0) begin
        if (in_data_x)
          nx.col = ci_ext[bs_n] ? C_YEL : C_BLU;
      end else if (!by[0] && ri_n < 11'(ROWS)) begin
        if (bx < 11'd8)
          nx.col = lab8[~bx[2:0]] ? C_YEL : C_BLU;
        else if (in_data_x)
          nx.data = 1'b1;
      end
    end
  end

  assign tail = pipe_q[RAM_LAT-1];

  always_comb begin
    bit_v   = 1'b0;
    out_col = tail.col;
    if (tail.data) begin
      bit_v = ram.ram_data[tail.bs];
      if (tail.hit)
        out_col = bit_v ? C_WHT : C_CYN;
      else
        out_col = bit_v ? C_YEL : C_BLU;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph_q         <= '0;
      ci_q         <= '0;
      ri_q         <= '0;
      base_q       <= '0;
      ram.ram_addr <= '0;
      vga_r        <= 1'b0;
      vga_g        <= 1'b0;
      vga_b        <= 1'b0;
      for (int i = 0; i < RAM_LAT; i++)
        pipe_q[i] <= '0;
    end else begin
      ph_q         <= ph_n;
      ci_q         <= ci_n;
      ri_q         <= ri_n;
      if (frame_start)
        base_q <= base_row;
      ram.ram_addr <= addr_n;
      pipe_q[0]    <= nx;
      for (int i = 1; i < RAM_LAT; i++)
        pipe_q[i] <= pipe_q[i-1];
      {vga_r, vga_g, vga_b} <= in_display ? out_col : C_BLACK;
    end
  end
endmodule

// File: tb/tb_binary_grid_display.sv
// Directed bench: sweeps short synthetic frames through a latency-1 and a latency-2 instance and
// compares captured pixels against a hand-computed vector table.
module tb_binary_grid_display;
  localparam logic [2:0] K = 3'b000, Y = 3'b110, B = 3'b001, W = 3'b111, C = 3'b011;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [10:0] cx = '0, cy = '0;
  logic        de = 1'b1;
  logic [5:0]  base_row = '0;
  logic [9:0]  cursor_addr = 10'h011;
  logic        r1, g1, b1, r2, g2, b2;

  binary_grid_if #(.DATA_W(8), .ADDR_W(10)) bus1 ();
  binary_grid_if #(.DATA_W(8), .ADDR_W(10)) bus2 ();

  binary_grid_display #(.RAM_LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .counter_x(cx), .counter_y(cy), .in_display(de),
    .base_row(base_row), .cursor_addr(cursor_addr), .ram(bus1),
    .vga_r(r1), .vga_g(g1), .vga_b(b1));

  binary_grid_display #(.RAM_LAT(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .counter_x(cx), .counter_y(cy), .in_display(de),
    .base_row(base_row), .cursor_addr(cursor_addr), .ram(bus2),
    .vga_r(r2), .vga_g(g2), .vga_b(b2));

  always #5 clk = ~clk;

  // RAM models: data consumed RAM_LAT cycles after the counters that addressed it.
  logic [7:0] mem [1024];
  logic [9:0] a2_d;
  always @(posedge clk) a2_d <= bus2.ram_addr;
  assign bus1.ram_data = mem[bus1.ram_addr];
  assign bus2.ram_data = mem[a2_d];

  typedef struct {
    int         frm;
    int         unit;
    int         x;
    int         y;
    logic [2:0] exp;
  } vec_t;

  vec_t       vecs[$];
  logic [2:0] cap1 [int];
  logic [2:0] cap2 [int];
  int         hx[4] = '{-1, -1, -1, -1};
  int         hy[4] = '{-1, -1, -1, -1};
  bit         long_line [2048];
  int         n_tests = 0;
  int         n_fail = 0;

  task automatic chk(string name, logic [15:0] got, logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic add_v(int f, int u, int x, int y, logic [2:0] e);
    vecs.push_back('{f, u, x, y, e});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 3; i > 0; i--) begin
      hx[i] = hx[i-1];
      hy[i] = hy[i-1];
    end
    hx[0] = int'(cx);
    hy[0] = int'(cy);
    if (hx[1] >= 0) cap1[hy[1]*4096 + hx[1]] = {r1, g1, b1};
    if (hx[2] >= 0) cap2[hy[2]*4096 + hx[2]] = {r2, g2, b2};
  endtask

  task automatic clear_hist();
    for (int i = 0; i < 4; i++) begin
      hx[i] = -1;
      hy[i] = -1;
    end
  endtask

  task automatic run_frame(int ymax, int xlong, int chg_y, logic [5:0] chg_val);
    cap1.delete();
    cap2.delete();
    for (int y = 0; y <= ymax; y++) begin
      if (y == chg_y) base_row = chg_val;
      for (int x = 0; x <= (long_line[y] ? xlong : 7); x++) begin
        cx = 11'(x);
        cy = 11'(y);
        de = (y != 19);
        tick();
      end
    end
    for (int k = 0; k < 3; k++) begin
      cx = 11'd1;
      cy = 11'd2047;
      de = 1'b1;
      tick();
    end
  endtask

  task automatic check_frame(int f);
    foreach (vecs[i]) begin
      if (vecs[i].frm == f) begin
        int         k;
        logic [2:0] got;
        k   = vecs[i].y*4096 + vecs[i].x;
        got = 3'bxxx;
        if (vecs[i].unit == 1) begin
          if (cap1.exists(k)) got = cap1[k];
        end else if (cap2.exists(k)) begin
          got = cap2[k];
        end
        chk($sformatf("pix_f%0d_u%0d_x%0d_y%0d", f, vecs[i].unit, vecs[i].x, vecs[i].y),
            16'(got), 16'(vecs[i].exp));
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    clear_hist();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    mem[0]   = 8'hA5;
    mem[15]  = 8'h01;
    mem[17]  = 8'h80;
    mem[80]  = 8'h0F;
    mem[160] = 8'hC3;
    mem[992] = 8'hF0;
    for (int i = 0; i < 2048; i++) long_line[i] = 1'b0;
    foreach (long_line[i])
      if (i == 3 || i == 12 || i == 16 || i == 17 || i == 18 || i == 19 || i == 33 ||
          i == 49 || i == 209 || i == 1027 || i == 1043)
        long_line[i] = 1'b1;

    // frame 1: base 0
    add_v(1, 1, 73, 17, Y);   add_v(1, 1, 79, 17, Y);   add_v(1, 1, 81, 17, B);
    add_v(1, 1, 87, 17, B);   add_v(1, 1, 72, 17, K);   add_v(1, 1, 80, 17, K);
    add_v(1, 1, 140, 17, K);  add_v(1, 1, 90, 17, Y);   add_v(1, 1, 100, 17, B);
    add_v(1, 1, 67, 17, K);   add_v(1, 1, 3, 17, B);    add_v(1, 1, 75, 16, K);
    add_v(1, 1, 3, 3, K);     add_v(1, 1, 75, 3, B);    add_v(1, 1, 147, 3, B);
    add_v(1, 1, 203, 3, Y);   add_v(1, 1, 1187, 3, Y);  add_v(1, 1, 1179, 3, B);
    add_v(1, 1, 1230, 3, K);  add_v(1, 1, 75, 12, K);   add_v(1, 1, 1211, 17, Y);
    add_v(1, 1, 1203, 17, B); add_v(1, 1, 1227, 17, K); add_v(1, 1, 1300, 17, K);
    add_v(1, 1, 19, 1027, Y); add_v(1, 1, 73, 1027, B); add_v(1, 1, 75, 1043, K);
    add_v(1, 1, 3, 1043, K);  add_v(1, 1, 75, 18, Y);   add_v(1, 1, 75, 19, K);
    add_v(1, 2, 72, 17, K);   add_v(1, 2, 73, 17, Y);   add_v(1, 2, 81, 17, B);
    add_v(1, 2, 3, 3, K);     add_v(1, 2, 203, 3, Y);   add_v(1, 2, 147, 3, B);
    add_v(1, 2, 1187, 3, Y);  add_v(1, 2, 3, 17, B);
    // frame 2: base 62, base_row changed to 5 at y=200
    add_v(2, 1, 73, 17, Y);   add_v(2, 1, 105, 17, B);  add_v(2, 1, 3, 17, B);
    add_v(2, 1, 19, 17, Y);   add_v(2, 1, 59, 17, B);   add_v(2, 1, 73, 49, Y);
    add_v(2, 1, 81, 49, B);   add_v(2, 1, 19, 49, B);   add_v(2, 1, 35, 209, Y);
    add_v(2, 1, 51, 209, Y);  add_v(2, 1, 59, 209, B);  add_v(2, 1, 73, 209, Y);
    add_v(2, 1, 89, 209, B);  add_v(2, 2, 19, 17, Y);   add_v(2, 2, 73, 209, Y);
    // frame 3: base 5
    add_v(3, 1, 73, 17, B);   add_v(3, 1, 113, 17, Y);  add_v(3, 1, 43, 17, Y);
    add_v(3, 1, 35, 17, B);   add_v(3, 2, 113, 17, Y);
`ifdef BINARY_GRID_CURSOR_EN
    add_v(131, 1, 147, 33, Y); add_v(131, 1, 155, 33, B);
    add_v(132, 1, 147, 33, W); add_v(132, 1, 155, 33, C); add_v(132, 1, 147, 17, B);
    add_v(132, 1, 73, 17, Y);
    add_v(163, 1, 147, 33, W); add_v(163, 1, 155, 33, C);
    add_v(164, 1, 147, 33, Y); add_v(164, 1, 155, 33, B);
`endif

    do_reset();
    chk("reset_vga1", 16'({r1, g1, b1}), 16'(K));
    chk("reset_addr1", 16'(bus1.ram_addr), 16'd0);

    // partial frame, then asynchronous reset in the middle of line 17
    for (int y = 0; y <= 16; y++)
      for (int x = 0; x <= 7; x++) begin
        cx = 11'(x); cy = 11'(y); de = 1'b1; tick();
      end
    for (int x = 0; x <= 77; x++) begin
      cx = 11'(x); cy = 11'd17; tick();
    end
    chk("pre_rst_vga1", 16'({r1, g1, b1}), 16'(Y));
    chk("pre_rst_vga2", 16'({r2, g2, b2}), 16'(Y));
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_vga1", 16'({r1, g1, b1}), 16'(K));
    chk("midrst_vga2", 16'({r2, g2, b2}), 16'(K));
    chk("midrst_addr1", 16'(bus1.ram_addr), 16'd0);
    chk("midrst_addr2", 16'(bus2.ram_addr), 16'd0);
    cx = 11'd78; tick();
    cx = 11'd79; tick();
    chk("rst_hold_vga1", 16'({r1, g1, b1}), 16'(K));
    #3 rst_n = 1'b1;
    clear_hist();

    run_frame(1043, 1310, -1, 6'd0);
    check_frame(1);
    base_row = 6'd62;
    run_frame(210, 1310, 200, 6'd5);
    check_frame(2);
    run_frame(20, 1310, -1, 6'd0);
    check_frame(3);

    // explicit latency sequence around the first yellow cell of row 0
    base_row = 6'd0;
    for (int y = 0; y <= 16; y++)
      for (int x = 0; x <= 7; x++) begin
        cx = 11'(x); cy = 11'(y); de = 1'b1; tick();
      end
    for (int x = 0; x <= 72; x++) begin
      cx = 11'(x); cy = 11'd17; tick();
    end
    cx = 11'd73; tick();
    chk("lat1_e1", 16'({r1, g1, b1}), 16'(K));
    chk("lat2_e1", 16'({r2, g2, b2}), 16'(K));
    cx = 11'd74; tick();
    chk("lat1_e2", 16'({r1, g1, b1}), 16'(Y));
    chk("lat2_e2", 16'({r2, g2, b2}), 16'(K));
    cx = 11'd75; tick();
    chk("lat2_e3", 16'({r2, g2, b2}), 16'(Y));

`ifdef BINARY_GRID_CURSOR_EN
    do_reset();
    for (int n = 1; n <= 64; n++) begin
      run_frame(33, 160, -1, 6'd0);
      check_frame(100 + n);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/binary_grid_display.md
# binary_grid_display

Parametrised successor to the 1280x1024 debug-RAM binary viewer. It renders a grid of RAM words as coloured bit cells: one cell per bit, each word preceded by a row-number label and topped by a column-index header. The word width, grid size, cell size and RAM read latency are parameters. The block also adds frame-latched vertical scrolling and an optional blinking cursor. It sits between the VESA sync generator (counters in) and the VGA pins, and drives the read port of a synchronous debug RAM.

## Interface
- `DATA_W`, 8: bits per RAM word, 1..16.
- `COLS`, 16: words per displayed row, power of 2.
- `ROWS`, 64: RAM rows, power of 2.
- `CELL_LOG2`, 3: cell edge is 2^CELL_LOG2 pixels, 2..4.
- `RAM_LAT`, 1: RAM read latency in clocks, 1..3.
- `ADDR_W`, log2(ROWS)+log2(COLS): RAM address width, derived.
- `clk` in 1: pixel clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `counter_x` in 11: prefetch-adjusted horizontal pixel counter.
- `counter_y` in 11: vertical pixel counter.
- `in_display` in 1: visible-area flag, aligned to the outgoing pixel.
- `base_row` in log2(ROWS): scroll offset.
- `cursor_addr` in ADDR_W: highlighted word.
- `ram_addr` out ADDR_W: RAM read address, registered.
- `ram_data` in DATA_W: RAM read data, valid RAM_LAT clocks after `ram_addr`.
- `vga_r`, `vga_g`, `vga_b` out 1 each: registered colour outputs.

## Operation
- Cell coordinates are bx = counter_x >> CELL_LOG2 and by = counter_y >> CELL_LOG2. Pitch P = DATA_W+1.
- The modulo is not computed by division. Instead, sequential counters `col_phase` (0..DATA_W) and `col_idx` advance at cell boundaries.
  - Both counters clear when counter_x == 0.
  - `row_idx` clears when counter_y == 0 and advances every 2 cell rows from by == 2.
- Horizontal layout:
  - bx 0..7 is the label field.
  - bx 8 is the gap.
  - Data column c occupies bx 9+P·c .. 9+P·c+DATA_W-1, with the MSB first, followed by one gap cell.
- Vertical layout:
  - by 0 is the header.
  - Odd by is a gap.
  - Even by ≥ 2 is data row (by-2)/2.
- Colours:
  - Bit value 1 is 3'b110 (yellow). Bit value 0 is 3'b001 (blue).
  - Gaps are 3'b000.
  - Grid lines are 3'b000: pixels where counter_x[CELL_LOG2-1:0] == 0 or counter_y[CELL_LOG2-1:0] == 0.
  - Columns ≥ COLS and data rows ≥ ROWS are 3'b000.
- Header shows the low DATA_W bits of c, MSB first. The label field in the header row is black.
- Scrolling:
  - `base_q` latches `base_row` when counter_x == 0 and counter_y == 0. Changes to `base_row` mid-frame have no effect until the next frame.
  - RAM row r = (base_q + row_idx) mod ROWS, which wraps naturally.
  - ram_addr = {r, c}.
  - The label shows the low 8 bits of r, zero-extended, MSB first.
- Non-data colours travel through a delay line of RAM_LAT stages, so they stay aligned with `ram_data`.
- Reset values: vga_r/g/b = 0; ram_addr = 0; base_q, counters, pipeline and blink counter = 0.
- Asserting `rst_n` mid-frame forces black output immediately. Counters stay cleared until release; the first full frame after release is correct.

## Timing
- Pixel colour for counter position (x, y) appears on vga_* exactly RAM_LAT+1 clocks after (x, y) is presented. The sync generator's prefetch offset must equal RAM_LAT+1.
- `in_display` gates the final register stage with no internal delay. Outside the visible area the outputs are 0.
- `ram_addr` updates on the clock after the counter values that select it.

## Configuration
- `BINARY_GRID_CURSOR_EN` defined:
  - A 6-bit frame counter increments at each frame start.
  - When ram_addr == cursor_addr and frame_cnt[5] == 1, data bits render as 3'b111 (white) for 1 and 3'b011 (cyan) for 0.
  - Gaps and grid lines are unchanged.
- Undefined:
  - `cursor_addr` is ignored.
  - No frame counter is built, and there is no highlight.

## Test plan
- Scenario 1, reset mid-line:
  - Stimulus: rst_n=0 asynchronously at an arbitrary x.
  - Response: vga_* = 000 within the same cycle; ram_addr = 0.
- Scenario 2, default-parameter data cell:
  - Stimulus: defaults, base_row=0, RAM[0]=0xA5, y=17..23.
  - Response: x=73..79 yellow, x=81..87 blue, x=72 black (grid), bx=17 black (gap).
- Scenario 3, scrolling and wrap:
  - Stimulus: base_row=62.
  - Response: data row 0 reads row 62 (label 0x3E), data row 2 reads row 0.
  - Stimulus: change base_row to 5 at y=200.
  - Response: the current frame is unchanged; the next frame starts at row 5.
- Scenario 4, latency:
  - Stimulus: RAM_LAT=2 with a RAM model of latency 2.
  - Response: the first yellow pixel appears 3 clocks after x=73 is presented, and the header/label alignment also has a 3-clock delay.
- Scenario 5, out of range:
  - Stimulus: defaults.
  - Response: bx ≥ 153 black on all rows; data row 64 (by=130) black.
- Scenario 6, cursor (macro defined):
  - Stimulus: cursor_addr=0x011, RAM[0x011]=0x80.
  - Response: frames 32..63 show the MSB cell white and the others cyan; frames 0..31 show yellow/blue.
